// File: rtl/stack_machine_core_if.sv
// Bus bundle between the stack machine core and its program ROM / status observers.
// The ROM is asynchronous-read with no valid/ready pair: the core drives rom_addr
// and consumes rom_data combinationally in the same cycle, and every status output
// is a registered view of the core state, valid every cycle after reset.
interface stack_machine_core_if #(
  parameter int WORD_WIDTH  = 16,
  parameter int STACK_DEPTH = 32,
  parameter int ROM_DEPTH   = 1024
);
  localparam int AW  = $clog2(ROM_DEPTH) + 1;
  localparam int SPW = $clog2(STACK_DEPTH) + 1;

  logic [AW-1:0]         rom_addr;
  logic [7:0]            rom_data;
  logic                  halted;
  logic                  error;
  logic [2:0]            err_code;
  logic [AW-1:0]         pc;
  logic [SPW-1:0]        sp;
  logic [WORD_WIDTH-1:0] top;
  logic [1:0]            dbg_state;

  modport master (
    output rom_addr, halted, error, err_code, pc, sp, top, dbg_state,
    input  rom_data
  );

  modport slave (
    input  rom_addr, halted, error, err_code, pc, sp, top, dbg_state,
    output rom_data
  );
endinterface

// File: rtl/stack_machine_core.sv
// Byte-opcode stack machine: fetches from an external async ROM and executes an
// EVM-style subset (PUSHn, DUP/SWAP, ALU ops, JUMP/JUMPI) on an internal word stack.
// Faults are detected before any state change and leave stack, sp and pc untouched.
module stack_machine_core #(
  parameter int WORD_WIDTH  = 16,
  parameter int STACK_DEPTH = 32,
  parameter int ROM_DEPTH   = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  stack_machine_core_if.master       bus
);
  localparam int AW  = $clog2(ROM_DEPTH) + 1;
  localparam int SPW = $clog2(STACK_DEPTH) + 1;
  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_IMM  = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [AW-1:0]         pc_q, pc_d;
  logic [SPW-1:0]        sp_q, sp_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] acc_q, acc_d;
  logic                  halted_q, halted_d;
  logic                  error_q, error_d;
  logic [2:0]            err_q, err_d;
  logic [WORD_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [WORD_WIDTH-1:0] stack_d [STACK_DEPTH];

  logic [7:0]            op;
  logic                  op_ok, is_bin, is_un, is_push;
  logic [5:0]            need;
  logic                  under, over, bad_jump;
  logic [2:0]            fault;
  logic [IW-1:0]         ia, ib, ipush, idup, iswp;
  logic [WORD_WIDTH-1:0] a, b, alu;
  logic [7:0]            imm_byte;
  logic [WORD_WIDTH-1:0] acc_n;

  // Opcode classification and required stack depth for the byte at pc.
  always_comb begin
    op      = bus.rom_data;
    op_ok   = 1'b1;
    is_bin  = 1'b0;
    is_un   = 1'b0;
    is_push = 1'b0;
    need    = 6'd0;
    if (op inside {8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h14, 8'h16, 8'h17, 8'h18}) begin
      is_bin = 1'b1;
      need   = 6'd2;
    end else if (op == 8'h15 || op == 8'h19) begin
      is_un = 1'b1;
      need  = 6'd1;
    end else if (op == 8'h50 || op == 8'h56) begin
      need = 6'd1;
    end else if (op == 8'h57) begin
      need = 6'd2;
    end else if (op == 8'h00) begin
      need = 6'd0;
    end else if (op == 8'h5F || op[7:5] == 3'b011) begin
      is_push = 1'b1;
    end else if (op[7:4] == 4'h8) begin
      is_push = 1'b1;
      need    = 6'(op[3:0]) + 6'd1;
    end else if (op[7:4] == 4'h9) begin
      need = 6'(op[3:0]) + 6'd2;
    end else begin
      op_ok = 1'b0;
    end
  end

  // Stack operand fetch, ALU and fault detection (priority: opcode, underflow, overflow, jump).
  always_comb begin
    ia    = IW'(sp_q - SPW'(1));
    ib    = IW'(sp_q - SPW'(2));
    ipush = IW'(sp_q);
    idup  = IW'(sp_q - SPW'(op[3:0]) - SPW'(1));
    iswp  = IW'(sp_q - SPW'(op[3:0]) - SPW'(2));
    a     = stack_q[ia];
    b     = stack_q[ib];
    case (op)
      8'h01:   alu = a + b;
      8'h02:   alu = a * b;
      8'h03:   alu = a - b;
      8'h10:   alu = WORD_WIDTH'(a < b);
      8'h11:   alu = WORD_WIDTH'(a > b);
      8'h14:   alu = WORD_WIDTH'(a == b);
      8'h15:   alu = WORD_WIDTH'(a == '0);
      8'h16:   alu = a & b;
      8'h17:   alu = a | b;
      8'h18:   alu = a ^ b;
      8'h19:   alu = ~a;
      default: alu = '0;
    endcase
    under    = 32'(sp_q) < 32'(need);
    over     = is_push && (sp_q == SPW'(STACK_DEPTH));
    bad_jump = ((op == 8'h56) || (op == 8'h57 && b != '0)) && (64'(a) >= 64'(ROM_DEPTH));
    if (!op_ok)        fault = 3'd3;
    else if (under)    fault = 3'd1;
    else if (over)     fault = 3'd2;
    else if (bad_jump) fault = 3'd4;
    else               fault = 3'd0;
  end

  // Next-state logic for the IDLE/EXEC/IMM/HALT sequencer and the stack.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    sp_d     = sp_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    halted_d = halted_q;
    error_d  = error_q;
    err_d    = err_q;
    stack_d  = stack_q;
    // Immediate bytes past the end of the ROM read as zero.
    imm_byte = (pc_q >= AW'(ROM_DEPTH)) ? 8'h00 : bus.rom_data;
    acc_n    = WORD_WIDTH'({acc_q, imm_byte});
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_EXEC;
          pc_d    = '0;
        end
      end
      S_EXEC: begin
        if (pc_q >= AW'(ROM_DEPTH)) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else if (fault != 3'd0) begin
          halted_d = 1'b1;
          error_d  = 1'b1;
          err_d    = fault;
          state_d  = S_HALT;
        end else begin
          pc_d = pc_q + AW'(1);
          if (is_bin) begin
            stack_d[ib] = alu;
            sp_d        = sp_q - SPW'(1);
          end else if (is_un) begin
            stack_d[ia] = alu;
          end else begin
            case (op)
              8'h00: begin
                pc_d     = pc_q;
                halted_d = 1'b1;
                state_d  = S_HALT;
              end
              8'h50: sp_d = sp_q - SPW'(1);
              8'h56: begin
                pc_d = AW'(a);
                sp_d = sp_q - SPW'(1);
              end
              8'h57: begin
                if (b != '0) pc_d = AW'(a);
                sp_d = sp_q - SPW'(2);
              end
              8'h5F: begin
                stack_d[ipush] = '0;
                sp_d           = sp_q + SPW'(1);
              end
              default: begin
                if (op[7:5] == 3'b011) begin
                  cnt_d   = 6'(op - 8'h5F);
                  acc_d   = '0;
                  state_d = S_IMM;
                end else if (op[7:4] == 4'h8) begin
                  stack_d[ipush] = stack_q[idup];
                  sp_d           = sp_q + SPW'(1);
                end else begin
                  stack_d[ia]   = stack_q[iswp];
                  stack_d[iswp] = a;
                end
              end
            endcase
          end
        end
      end
      S_IMM: begin
        pc_d  = pc_q + AW'(1);
        acc_d = acc_n;
        if (cnt_q == 6'd1) begin
          stack_d[ipush] = acc_n;
          sp_d           = sp_q + SPW'(1);
          state_d        = S_EXEC;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      default: begin
      end
    endcase
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      sp_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
      err_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      sp_q     <= sp_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      halted_q <= halted_d;
      error_q  <= error_d;
      err_q    <= err_d;
    end
  end

  // Stack storage is not reset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign bus.rom_addr  = pc_q;
  assign bus.pc        = pc_q;
  assign bus.sp        = sp_q;
  assign bus.halted    = halted_q;
  assign bus.error     = error_q;
  assign bus.err_code  = err_q;
  assign bus.dbg_state = state_q;
  assign bus.top       = (sp_q == '0) ? '0 : stack_q[ia];
endmodule

// File: tb/tb_stack_machine_core.sv
// Bench for stack_machine_core: two instances (default sizing and a small
// STACK_DEPTH=4 / ROM_DEPTH=16 build) driven from bench-owned ROM images.
module tb_stack_machine_core;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_IMM  = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic run_a, run_b;

  stack_machine_core_if #(.WORD_WIDTH(16), .STACK_DEPTH(32), .ROM_DEPTH(1024)) bus_a ();
  stack_machine_core_if #(.WORD_WIDTH(16), .STACK_DEPTH(4),  .ROM_DEPTH(16))   bus_b ();

  stack_machine_core #(.WORD_WIDTH(16), .STACK_DEPTH(32), .ROM_DEPTH(1024)) dut_a (
    .clk(clk), .rst(rst), .run(run_a), .bus(bus_a.master)
  );
  stack_machine_core #(.WORD_WIDTH(16), .STACK_DEPTH(4), .ROM_DEPTH(16)) dut_b (
    .clk(clk), .rst(rst), .run(run_b), .bus(bus_b.master)
  );

  logic [7:0] rom_a [1024];
  logic [7:0] rom_b [16];
  assign bus_a.rom_data = (bus_a.rom_addr < 11'd1024) ? rom_a[bus_a.rom_addr[9:0]] : 8'h00;
  assign bus_b.rom_data = (bus_b.rom_addr < 5'd16) ? rom_b[bus_b.rom_addr[3:0]] : 8'h00;

  // scoreboard
  logic [31:0] exp_q [$];
  logic [7:0]  prog [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  string       fld [6] = '{"halted", "error", "err_code", "pc", "sp", "top"};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int sel, input int f);
    logic [31:0] r;
    r = '0;
    case (f)
      0: r = (sel == 0) ? 32'(bus_a.halted)    : 32'(bus_b.halted);
      1: r = (sel == 0) ? 32'(bus_a.error)     : 32'(bus_b.error);
      2: r = (sel == 0) ? 32'(bus_a.err_code)  : 32'(bus_b.err_code);
      3: r = (sel == 0) ? 32'(bus_a.pc)        : 32'(bus_b.pc);
      4: r = (sel == 0) ? 32'(bus_a.sp)        : 32'(bus_b.sp);
      5: r = (sel == 0) ? 32'(bus_a.top)       : 32'(bus_b.top);
      6: r = (sel == 0) ? 32'(bus_a.dbg_state) : 32'(bus_b.dbg_state);
      default: r = '0;
    endcase
    return r;
  endfunction

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load(input int sel);
    for (int i = 0; i < 1024; i++)
      if (sel == 0) rom_a[i] = (i < prog.size()) ? prog[i] : 8'h00;
    for (int i = 0; i < 16; i++)
      if (sel == 1) rom_b[i] = (i < prog.size()) ? prog[i] : 8'h00;
  endtask

  task automatic expect_end(input logic [31:0] h, input logic [31:0] e, input logic [31:0] c,
                            input logic [31:0] p, input logic [31:0] s, input logic [31:0] t);
    exp_q.push_back(h);
    exp_q.push_back(e);
    exp_q.push_back(c);
    exp_q.push_back(p);
    exp_q.push_back(s);
    exp_q.push_back(t);
  endtask

  task automatic run_prog(input int sel, input int max_cycles, output int cycles);
    @(negedge clk);
    if (sel == 0) run_a = 1'b1; else run_b = 1'b1;
    @(negedge clk);
    run_a = 1'b0;
    run_b = 1'b0;
    cycles = 0;
    while (obs(sel, 0) == 32'd0 && cycles < max_cycles) begin
      @(negedge clk);
      cycles++;
    end
    if (obs(sel, 0) == 32'd0) check("halt_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_end(input int sel, input string name);
    for (int f = 0; f < 6; f++) begin
      if (exp_q.size() == 0) check({name, ".sb_empty"}, 32'd0, 32'd1);
      else check({name, ".", fld[f]}, obs(sel, f), exp_q.pop_front());
    end
  endtask

  task automatic run_and_check(input int sel, input string name);
    int cyc;
    do_reset();
    load(sel);
    run_prog(sel, 500, cyc);
    check_end(sel, name);
  endtask

  function automatic logic [15:0] model(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] t;
    t = '0;
    case (op)
      8'h01: t = {16'h0, a} + {16'h0, b};
      8'h02: t = {16'h0, a} * {16'h0, b};
      8'h03: t = {16'h0, a} + {16'h0, ~b} + 32'd1;
      8'h10: t = (a < b) ? 32'd1 : 32'd0;
      8'h11: t = (a > b) ? 32'd1 : 32'd0;
      8'h14: t = (a == b) ? 32'd1 : 32'd0;
      8'h15: t = (a == 16'h0) ? 32'd1 : 32'd0;
      8'h16: t = {16'h0, a & b};
      8'h17: t = {16'h0, a | b};
      8'h18: t = {16'h0, a ^ b};
      8'h19: t = {16'h0, ~a};
      default: t = '0;
    endcase
    return t[15:0];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [7:0]  op_tab [11] = '{8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
    logic [7:0]  op;
    logic [15:0] x, y;

    rst = 1'b0;
    run_a = 1'b0;
    run_b = 1'b0;
    prog = {};
    load(0);
    load(1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    // reset state
    for (int f = 0; f < 6; f++) check({"reset.", fld[f]}, obs(0, f), 32'd0);
    check("reset.state", obs(0, 6), 32'(ST_IDLE));
    check("reset_b.sp", obs(1, 4), 32'd0);

    // PUSH1 3, PUSH1 5, ADD, STOP with latency check
    do_reset();
    prog = '{8'h60, 8'h03, 8'h60, 8'h05, 8'h01, 8'h00};
    load(0);
    expect_end(1, 0, 0, 5, 1, 16'h0008);
    run_prog(0, 100, cyc);
    check("add.cycles", 32'(cyc), 32'd6);
    check_end(0, "add");

    // underflow, HALT ignores run, reset re-arms
    prog = '{8'h01};
    expect_end(1, 1, 1, 0, 0, 0);
    run_and_check(0, "under");
    @(negedge clk); run_a = 1'b1;
    repeat (3) @(negedge clk);
    run_a = 1'b0;
    check("halt_sticky.state", obs(0, 6), 32'(ST_HALT));
    check("halt_sticky.pc", obs(0, 3), 32'd0);
    expect_end(1, 1, 1, 0, 0, 0);
    run_and_check(0, "rearm");

    // overflow on the 4-entry build
    prog = '{8'h5F, 8'h5F, 8'h5F, 8'h5F, 8'h5F};
    expect_end(1, 1, 2, 4, 4, 0);
    run_and_check(1, "overflow");

    // multi-byte pushes, big-endian with truncation
    prog = '{8'h61, 8'h12, 8'h34, 8'h62, 8'hAB, 8'hCD, 8'hEF, 8'h00};
    expect_end(1, 0, 0, 7, 2, 16'hCDEF);
    run_and_check(0, "pushn");
    prog = '{8'h61, 8'h12, 8'h34, 8'h62, 8'hAB, 8'hCD, 8'hEF, 8'h50, 8'h00};
    expect_end(1, 0, 0, 8, 1, 16'h1234);
    run_and_check(0, "pushn_pop");

    // countdown loop with JUMPI
    prog = '{8'h60, 8'h03, 8'h60, 8'h01, 8'h90, 8'h03, 8'h80, 8'h60, 8'h02, 8'h57, 8'h00};
    expect_end(1, 0, 0, 10, 1, 0);
    run_and_check(0, "loop");

    // bad jump and invalid opcode
    prog = '{8'h60, 8'hFF, 8'h56};
    expect_end(1, 1, 4, 2, 1, 16'h00FF);
    run_and_check(1, "badjump");
    prog = '{8'hFE};
    expect_end(1, 1, 3, 0, 0, 0);
    run_and_check(0, "invalid");

    // JUMPI not taken with out-of-range target is not a fault
    prog = '{8'h60, 8'h00, 8'h61, 8'hFF, 8'hFF, 8'h57, 8'h00};
    expect_end(1, 0, 0, 6, 0, 0);
    run_and_check(1, "jumpi_nt");

    // running off the end of ROM halts cleanly
    prog = {};
    for (int i = 0; i < 8; i++) begin
      prog.push_back(8'h5F);
      prog.push_back(8'h50);
    end
    expect_end(1, 0, 0, 16, 0, 0);
    run_and_check(1, "rom_end");

    // DUP3 and SWAP2
    prog = '{8'h60, 8'h01, 8'h60, 8'h02, 8'h60, 8'h03, 8'h82, 8'h00};
    expect_end(1, 0, 0, 7, 4, 1);
    run_and_check(0, "dup3");
    prog = '{8'h60, 8'h01, 8'h60, 8'h02, 8'h60, 8'h03, 8'h91, 8'h50, 8'h50, 8'h00};
    expect_end(1, 0, 0, 9, 1, 3);
    run_and_check(0, "swap2");

    // random ALU operations: a = second push, b = first push
    for (int i = 0; i < 12; i++) begin
      op = op_tab[$urandom_range(0, 10)];
      x  = 16'($urandom_range(0, 65535));
      y  = 16'($urandom_range(0, 65535));
      if (i == 0) y = 16'h0000;
      if (i == 1) y = x;
      prog = '{8'h61, x[15:8], x[7:0], 8'h61, y[15:8], y[7:0], op, 8'h00};
      expect_end(1, 0, 0, 7, (op == 8'h15 || op == 8'h19) ? 32'd2 : 32'd1, 32'(model(op, y, x)));
      run_and_check(0, $sformatf("alu_%0h", op));
    end

    // async reset during the IMM phase of PUSH2
    do_reset();
    prog = '{8'h61, 8'h12, 8'h34, 8'h00};
    load(0);
    @(negedge clk); run_a = 1'b1;
    @(negedge clk); run_a = 1'b0;
    @(posedge clk);
    #1;
    check("mid_imm.state", obs(0, 6), 32'(ST_IMM));
    check("mid_imm.pc", obs(0, 3), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst.pc", obs(0, 3), 32'd0);
    check("async_rst.sp", obs(0, 4), 32'd0);
    check("async_rst.state", obs(0, 6), 32'(ST_IDLE));
    check("async_rst.halted", obs(0, 0), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    expect_end(1, 0, 0, 3, 1, 16'h1234);
    run_prog(0, 100, cyc);
    check_end(0, "after_rst");

    if (exp_q.size() != 0) check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/stack_machine_core.md
Name: stack_machine_core

Overview:
- Parametrised successor to the single-stack opcode executor.
- Fetches byte opcodes from an external asynchronous-read ROM and executes an EVM-style subset on an internal word stack.
- Adds multi-byte PUSHn, DUPn/SWAPn, arithmetic/logic ops, JUMP, full underflow/overflow/opcode/jump checking, and a halt/error status interface.
- Sits between program ROM and the debug/trace bench.

Parameters:
- WORD_WIDTH, 16, stack word width in bits (>=8).
- STACK_DEPTH, 32, number of stack entries.
- ROM_DEPTH, 1024, program bytes; valid addresses 0..ROM_DEPTH-1.
- ROM_FILE is not a parameter; the ROM is external.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- run  in  1  start request, sampled only in IDLE.
- rom_addr  out  AW=$clog2(ROM_DEPTH)+1  fetch address (equals pc).
- rom_data  in  8  ROM byte at rom_addr, valid in the same cycle.
- halted  out  1  core stopped (STOP, end of ROM or fault).
- error  out  1  halted due to fault.
- err_code  out  3  0 none, 1 underflow, 2 overflow, 3 invalid opcode, 4 bad jump.
- pc  out  AW  current program counter.
- sp  out  $clog2(STACK_DEPTH)+1  entry count.
- top  out  WORD_WIDTH  stack[sp-1], or 0 when sp==0.

Behaviour:
- Reset (rst low, async):
  - State goes to IDLE; pc=0, sp=0, halted=0, error=0, err_code=0.
  - Stack contents need not be cleared.
  - Reset mid-instruction aborts it with no partial push.
- FSM states: IDLE, EXEC, IMM, HALT.
  - IDLE, run=1: go to EXEC next edge, pc=0.
  - EXEC: decode rom_data; one instruction per cycle.
  - IMM: gather PUSHn immediates.
  - HALT: sticky until reset; run is ignored.
- Operand convention: a=stack[sp-1] (top), b=stack[sp-2]. Binary ops pop 2 and push 1 (sp-1). Results are truncated to WORD_WIDTH; booleans are 0/1.
- Opcodes:
  - 0x00 STOP.
  - 0x01 ADD a+b; 0x02 MUL a*b (low bits); 0x03 SUB a-b (mod 2^W).
  - 0x10 LT a<b; 0x11 GT a>b; 0x14 EQ (all unsigned).
  - 0x15 ISZERO (unary, in place); 0x16 AND; 0x17 OR; 0x18 XOR; 0x19 NOT (unary).
  - 0x50 POP.
  - 0x56 JUMP: pc=a, pops 1.
  - 0x57 JUMPI: if b!=0 then pc=a else pc+1; pops 2.
  - 0x5F PUSH0.
  - 0x60-0x7F PUSHn, n=op-0x5F.
  - 0x80-0x8F DUPk: push stack[sp-k].
  - 0x90-0x9F SWAPk: exchange top with stack[sp-1-k].
  - Any other value is invalid.
- pc update: +1 for all non-jump ops.
- PUSHn:
  - EXEC cycle loads counter=n, clears the accumulator, pc+1, goes to IMM.
  - Each IMM cycle: acc=(acc<<8)|rom_data, pc+1, counter-1.
  - On the cycle counter reaches 1: push acc (low WORD_WIDTH bits, big-endian byte order), return to EXEC.
  - Latency 1+n cycles.
  - Immediate bytes at pc>=ROM_DEPTH read as 0x00; rom_addr is still driven.
- Fault checks happen in EXEC before any state change.
  - Underflow: sp < required (binary 2, unary/POP/JUMP 1, JUMPI 2, DUPk k, SWAPk k+1).
  - Overflow: a push with sp==STACK_DEPTH (PUSHn checked at decode, before IMM).
  - Bad jump: taken target >= ROM_DEPTH.
  - Priority: invalid opcode > underflow > overflow > bad jump.
- On fault: stack, sp and pc are unchanged; halted=1, error=1, err_code set, go to HALT.
- STOP, or EXEC with pc==ROM_DEPTH: halted=1, error=0, pc unchanged.
- Outputs are registered state or decoded from it; top, sp and pc reflect the state after the last completed instruction.

Test Plan:
- ROM 60 03 60 05 01 00, run pulse -> ADD is executed 5 cycles after EXEC entry; halted=1, error=0, pc=5, sp=1, top=0x0008.
- ROM 01 -> halted, err_code=1, pc=0, sp=0; rst pulse then run -> same result, which proves reset re-arms the core.
- STACK_DEPTH=4, ROM 5F×5 -> err_code=2, pc=4, sp=4, top=0.
- ROM 61 12 34 62 AB CD EF 00 -> stack [0x1234, 0xCDEF], sp=2, pc=7; second push truncated to the low word.
- Countdown loop: 60 03, JUMPDEST-less body at 2: 60 01 90 03 80 60 02 57 00 -> iterates until top==0, halts at pc=0x0A, sp=1, top=0.
- ROM 60 FF 56 with ROM_DEPTH=16 -> err_code=4, pc=2, sp=1; FE -> err_code=3.
- rst driven low during IMM of PUSH2 -> outputs return to reset values immediately (async), sp=0.
